// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the master-arbiter state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef logic [2:0] hsize_t;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_DATA
  } arb_state_e;

endpackage

// File: rtl/ahb_lite_master_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i wins.
module rr_arbiter #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;
  logic          found;

  always_comb begin
    grant_o  = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (!found && req_i[cand_idx]) begin
        found             = 1'b1;
        grant_o[cand_idx] = 1'b1;
        idx_o             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/ahb_lite_master_arbiter.sv
// Multi-master AHB-Lite front end: captures each master's address phase,
// stalls it, and replays it on the single shared bus in round-robin order.
module ahb_lite_master_arbiter
  import ahb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*NUM_MASTERS-1:0]  m_htrans,
  input  logic [AW*NUM_MASTERS-1:0] m_haddr,
  input  logic [NUM_MASTERS-1:0]    m_hwrite,
  input  logic [3*NUM_MASTERS-1:0]  m_hsize,
  input  logic [DW*NUM_MASTERS-1:0] m_hwdata,
  output logic [NUM_MASTERS-1:0]    m_hready,
  output logic [NUM_MASTERS-1:0]    m_hresp,
  output logic [DW-1:0]             m_hrdata,
  output logic [1:0]                s_htrans,
  output logic [AW-1:0]             s_haddr,
  output logic                      s_hwrite,
  output logic [2:0]                s_hsize,
  output logic [DW-1:0]             s_hwdata,
  input  logic                      s_hready,
  input  logic                      s_hresp,
  input  logic [DW-1:0]             s_hrdata
);

  localparam int unsigned IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  arb_state_e             state_q;
  logic [IW-1:0]          owner_q, rr_q, win_idx;
  logic [NUM_MASTERS-1:0] owner_oh_q, win_oh;
  logic [NUM_MASTERS-1:0] pend_v_q, pend_v_d, accept, req, clr;
  logic [AW-1:0]          pend_addr_q [NUM_MASTERS];
  hsize_t                 pend_size_q [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] pend_write_q;
  logic                   in_data;

  assign in_data  = (state_q == ARB_DATA);
  assign m_hrdata = s_hrdata;

  // Per-master handshake: the data-phase owner follows the slave, others stall while pending.
  always_comb begin
    m_hready = '1;
    m_hresp  = '0;
    accept   = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (in_data && owner_oh_q[m]) begin
        m_hready[m] = s_hready;
        m_hresp[m]  = s_hresp;
      end else begin
        m_hready[m] = !pend_v_q[m];
        m_hresp[m]  = HRESP_OKAY;
      end
      accept[m] = m_hready[m] && (m_htrans[2*m +: 2] inside {NONSEQ, SEQ});
    end
  end

  // Same-cycle captures join arbitration so an uncontended request issues next cycle.
  always_comb begin
    req = pend_v_q | accept;
    clr = '0;
    if (state_q == ARB_ADDR && s_hready) clr = owner_oh_q;
    pend_v_d = req & ~clr;
  end

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_rr (
    .req_i   (req),
    .ptr_i   (rr_q),
    .grant_o (win_oh),
    .idx_o   (win_idx)
  );

  always_comb begin
    s_htrans = IDLE;
    s_haddr  = '0;
    s_hwrite = 1'b0;
    s_hsize  = '0;
    s_hwdata = '0;
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      if (owner_q == IW'(m)) begin
        if (state_q == ARB_ADDR) begin
          s_htrans = NONSEQ;
          s_haddr  = pend_addr_q[m];
          s_hwrite = pend_write_q[m];
          s_hsize  = pend_size_q[m];
        end
        if (in_data) s_hwdata = m_hwdata[DW*m +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      owner_oh_q   <= '0;
      rr_q         <= '0;
      pend_v_q     <= '0;
      pend_write_q <= '0;
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        pend_addr_q[m] <= '0;
        pend_size_q[m] <= '0;
      end
    end else begin
      pend_v_q <= pend_v_d;
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        if (accept[m]) begin
          pend_addr_q[m]  <= m_haddr[AW*m +: AW];
          pend_write_q[m] <= m_hwrite[m];
          pend_size_q[m]  <= m_hsize[3*m +: 3];
        end
      end
      unique case (state_q)
        ARB_IDLE: begin
          if (|req) begin
            owner_q    <= win_idx;
            owner_oh_q <= win_oh;
            state_q    <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (s_hready) begin
            state_q <= ARB_DATA;
            rr_q    <= (owner_q == IW'(NUM_MASTERS - 1)) ? '0 : owner_q + IW'(1);
          end
        end
        ARB_DATA: begin
          if (s_hready) begin
            if (|req) begin
              owner_q    <= win_idx;
              owner_oh_q <= win_oh;
              state_q    <= ARB_ADDR;
            end else begin
              state_q <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule
